fetch_queue_unit: RTL and testbench

//  IF stage of the pipelined 16-bit CPU, directly upstream of the ID-stage

---
 rtl/fetch_queue_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the fetch PC, issues I-cache word reads over a
// req/ready handshake and buffers returned words in a small FIFO for decode.
module fetch_queue_unit #(
    parameter int unsigned           WORD_SIZE   = 16,
    parameter int unsigned           DEPTH       = 2,
    parameter logic [WORD_SIZE-1:0]  RESET_PC    = '0,
    parameter logic [WORD_SIZE-1:0]  BUBBLE_INST = WORD_SIZE'(16'hB000)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 i_req,
    output logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_ready,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 is_stall,
    input  logic                 is_flush,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic                 inst_valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] i_addr_q, i_addr_d;
    logic                 i_req_q, i_req_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [WORD_SIZE-1:0] data_mem [DEPTH];
    logic [WORD_SIZE-1:0] pc_mem   [DEPTH];

    logic             deq;
    logic             enq;
    logic [CNT_W-1:0] occ;
    logic             space;
    logic             space_after;

    assign inst_valid  = (count_q != '0);
    assign deq         = inst_valid & ~is_stall & ~is_flush;
    assign occ         = count_q - CNT_W'(deq);
    assign space       = occ < CNT_W'(DEPTH);
    // Room for one more word after the one being accepted this cycle.
    assign space_after = (occ + CNT_W'(1)) < CNT_W'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        i_req_d    = i_req_q;
        i_addr_d   = i_addr_q;
        enq        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_flush) begin
                    fetch_pc_d = redirect_pc;
                end else if (space) begin
                    i_req_d  = 1'b1;
                    i_addr_d = fetch_pc_q;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (i_ready) begin
                    if (is_flush) begin
                        i_addr_d   = redirect_pc;
                        fetch_pc_d = redirect_pc;
                    end else begin
                        enq        = 1'b1;
                        fetch_pc_d = i_addr_q + WORD_SIZE'(1);
                        if (space_after) begin
                            i_addr_d = i_addr_q + WORD_SIZE'(1);
                        end else begin
                            i_req_d = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end else if (is_flush) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = StDrop;
                end
            end
            StDrop: begin
                // Stale request still in flight; its data is thrown away.
                if (is_flush) begin
                    fetch_pc_d = redirect_pc;
                end
                if (i_ready) begin
                    i_addr_d = fetch_pc_d;
                    state_d  = StBusy;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (is_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = occ + CNT_W'(enq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            i_req_q    <= 1'b0;
            i_addr_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            i_req_q    <= i_req_d;
            i_addr_q   <= i_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem[wr_ptr_q] <= i_data;
            pc_mem[wr_ptr_q]   <= i_addr_q;
        end
    end

    assign i_req   = i_req_q;
    assign i_addr  = i_addr_q;
    assign inst    = inst_valid ? data_mem[rd_ptr_q] : BUBBLE_INST;
    assign inst_pc = inst_valid ? pc_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit against a queue-based reference model,
// with a few directed scenarios (miss, stall, flush, mid-flight reset).
module tb_fetch_queue_unit;

    localparam int          DEPTH  = 2;
    localparam logic [15:0] BUBBLE = 16'hB000;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ready;
    logic [15:0] i_data;
    logic        is_stall;
    logic        is_flush;
    logic [15:0] redirect_pc;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;

    fetch_queue_unit #(
        .WORD_SIZE   (16),
        .DEPTH       (DEPTH),
        .RESET_PC    (16'h0000),
        .BUBBLE_INST (BUBBLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .is_stall    (is_stall),
        .is_flush    (is_flush),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of fetched words plus the one request slot.
    logic [15:0] q_data [$];
    logic [15:0] q_pc   [$];
    logic        m_req;
    logic        m_stale;
    logic [15:0] m_addr;
    logic [15:0] m_fpc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_pc.delete();
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_addr  = 16'h0000;
        m_fpc   = 16'h0000;
    endtask

    task automatic model_step();
        bit deq;
        int occ;
        deq = (q_data.size() > 0) && !is_stall && !is_flush;
        occ = q_data.size() - int'(deq);
        if (is_flush) begin
            q_data.delete();
            q_pc.delete();
        end else if (deq) begin
            void'(q_data.pop_front());
            void'(q_pc.pop_front());
        end
        if (!m_req) begin
            if (is_flush) m_fpc = redirect_pc;
            else if (occ < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end else if (m_stale) begin
            if (is_flush) m_fpc = redirect_pc;
            if (i_ready) begin
                m_addr  = m_fpc;
                m_stale = 1'b0;
            end
        end else if (i_ready && !is_flush) begin
            q_data.push_back(i_data);
            q_pc.push_back(m_addr);
            m_fpc = m_addr + 16'd1;
            if (occ + 1 < DEPTH) m_addr = m_addr + 16'd1;
            else m_req = 1'b0;
        end else if (i_ready) begin
            m_addr = redirect_pc;
            m_fpc  = redirect_pc;
        end else if (is_flush) begin
            m_fpc   = redirect_pc;
            m_stale = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = q_data.size() > 0;
        check_val("i_req", 32'(i_req), 32'(m_req));
        check_val("i_addr", 32'(i_addr), 32'(m_addr));
        check_val("inst_valid", 32'(inst_valid), 32'(v));
        check_val("inst", 32'(inst), v ? 32'(q_data[0]) : 32'(BUBBLE));
        check_val("inst_pc", 32'(inst_pc), v ? 32'(q_pc[0]) : 32'd0);
    endtask

    task automatic cycle(input logic rdy, input logic stl, input logic fl, input logic [15:0] rpc);
        i_ready     = rdy;
        is_stall    = stl;
        is_flush    = fl;
        redirect_pc = rpc;
        i_data      = 16'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_req"}, 32'(i_req), 32'd0);
        check_val({tag, "_addr"}, 32'(i_addr), 32'd0);
        check_val({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_val({tag, "_inst"}, 32'(inst), 32'(BUBBLE));
        check_val({tag, "_pc"}, 32'(inst_pc), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        i_ready     = 1'b0;
        i_data      = '0;
        is_stall    = 1'b0;
        is_flush    = 1'b0;
        redirect_pc = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Zero-latency cache: back-to-back requests 0,1,2.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check_val("t1_addr", 32'(i_addr), 32'd2);
        check_val("t1_inst_pc", 32'(inst_pc), 32'd1);

        // Miss on address 3.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            check_val("t2_addr", 32'(i_addr), 32'd3);
            check_val("t2_req", 32'(i_req), 32'd1);
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0);

        // Stall until the FIFO is full, then release.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0);
        check_val("t3_req", 32'(i_req), 32'd0);
        check_val("t3_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);

        // Flush during a miss, stale word dropped, then fetch from 0x40.
        cycle(1'b0, 1'b0, 1'b1, 16'h0040);
        check_val("t4_valid", 32'(inst_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check_val("t4_addr", 32'(i_addr), 32'h40);
        check_val("t4_valid2", 32'(inst_valid), 32'd0);

        // Flush coinciding with i_ready.
        cycle(1'b1, 1'b0, 1'b1, 16'h0080);
        check_val("t5_addr", 32'(i_addr), 32'h80);
        check_val("t5_valid", 32'(inst_valid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                  16'($urandom));
        end

        // Reset asserted while a request is outstanding.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        #1;
        check_reset_values("t6");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check_val("t6_req", 32'(i_req), 32'd1);
        check_val("t6_addr", 32'(i_addr), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
